gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_pkg.sv | 15 +
 rtl/settle_timer.sv | 29 ++
 rtl/gate_tt_checker.sv | 136 +++++++++++++
 tb/tb_gate_tt_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
package gate_tt_pkg;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Settling counter: counts up to TERMINAL (or down from it to zero) and flags the terminal count.
module settle_timer #(
    parameter int WIDTH      = 8,
    parameter int TERMINAL   = 9,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // Clear takes priority so the owner can restart a count on the same edge it stops counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= COUNT_DOWN ? WIDTH'(TERMINAL) : '0;
        end else if (enable) begin
            count <= COUNT_DOWN ? count - WIDTH'(1) : count + WIDTH'(1);
        end
    end

    assign tc = COUNT_DOWN ? (count == '0) : (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/gate_tt_checker.sv
// Drives all four {A,B} input combinations into a gate, samples Y after a settling
// delay, and reports the captured truth table against a latched expected value.
module gate_tt_checker #(
    parameter int SETTLE = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] tt,
    output logic       pass,
    output logic [2:0] mismatch_cnt,
    output logic [1:0] err_idx
);

    import gate_tt_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] vec;
    logic [3:0]       exp_q;
    logic             timer_clear;
    logic             timer_enable;
    logic             timer_tc;
    logic             last_vec;

    assign last_vec = (vec == VEC_W'(NUM_VEC - 1));

    settle_timer #(
        .WIDTH      (CNT_W),
        .TERMINAL   (SETTLE - 1),
        .COUNT_DOWN (1'b0)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= gate_tt_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        busy         = 1'b1;
        a_out        = 1'b0;
        b_out        = 1'b0;
        case (state)
            gate_tt_pkg::IDLE: begin
                busy = 1'b0;
                if (start) begin
                    timer_clear = 1'b1;
                    state_next  = gate_tt_pkg::SETTLE;
                end
            end
            gate_tt_pkg::SETTLE: begin
                {a_out, b_out} = vec;
                timer_enable   = 1'b1;
                if (timer_tc) begin
                    state_next = gate_tt_pkg::SAMPLE;
                end
            end
            gate_tt_pkg::SAMPLE: begin
                {a_out, b_out} = vec;
                timer_clear    = 1'b1;
                state_next     = last_vec ? gate_tt_pkg::REPORT : gate_tt_pkg::SETTLE;
            end
            gate_tt_pkg::REPORT: begin
                state_next = gate_tt_pkg::IDLE;
            end
            default: begin
                state_next = gate_tt_pkg::IDLE;
            end
        endcase
    end

    // Results are only touched on an accepted start, a sample, or the report, so they hold in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec          <= '0;
            exp_q        <= '0;
            tt           <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            err_idx      <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                gate_tt_pkg::IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        tt           <= '0;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        err_idx      <= '0;
                        vec          <= '0;
                    end
                end
                gate_tt_pkg::SAMPLE: begin
                    tt[vec] <= y_in;
                    if (y_in != exp_q[vec]) begin
                        mismatch_cnt <= mismatch_cnt + 3'd1;
                        if (mismatch_cnt == 3'd0) begin
                            err_idx <= vec;
                        end
                    end
                    if (!last_vec) begin
                        vec <= vec + VEC_W'(1);
                    end
                end
                gate_tt_pkg::REPORT: begin
                    done <= 1'b1;
                    pass <= (mismatch_cnt == 3'd0);
                    vec  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Table-driven bench for gate_tt_checker with a scoreboard of expected sweep results.
module tb_gate_tt_checker;

    localparam logic [2:0] M_AND    = 3'd0;
    localparam logic [2:0] M_XOR    = 3'd1;
    localparam logic [2:0] M_OR     = 3'd2;
    localparam logic [2:0] M_NAND   = 3'd3;
    localparam logic [2:0] M_TOGGLE = 3'd4;

    typedef struct {
        logic [2:0] model;
        logic [3:0] exp_in;
        logic [3:0] tt;
        logic       pass;
        logic [2:0] cnt;
        logic [1:0] err;
        bit         restarts;
        bit         report_start;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] expected;
    logic       a_out, b_out, y_in, busy, done, pass;
    logic [3:0] tt;
    logic [2:0] mismatch_cnt;
    logic [1:0] err_idx;

    logic       start1;
    logic [3:0] expected1;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] tt1;
    logic [2:0] cnt1;
    logic [1:0] err1;

    logic [2:0] model;
    logic [3:0] tog_pat;
    int         cyc;
    int         vec_cnt;
    int         miscomp;
    vec_t       tbl[6];
    vec_t       sb[$];

    always #5 clk = ~clk;

    gate_tt_checker #(.SETTLE(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .a_out(a_out), .b_out(b_out), .y_in(y_in), .busy(busy), .done(done),
        .tt(tt), .pass(pass), .mismatch_cnt(mismatch_cnt), .err_idx(err_idx)
    );

    gate_tt_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
        .a_out(a1), .b_out(b1), .y_in(y1), .busy(busy1), .done(done1),
        .tt(tt1), .pass(pass1), .mismatch_cnt(cnt1), .err_idx(err1)
    );

    assign y1 = a1 | b1;

    // The toggle model only shows the intended value during the SAMPLE cycle of each vector.
    always_comb begin
        y_in = 1'b0;
        case (model)
            M_AND:    y_in = a_out & b_out;
            M_XOR:    y_in = a_out ^ b_out;
            M_OR:     y_in = a_out | b_out;
            M_NAND:   y_in = ~(a_out & b_out);
            M_TOGGLE: y_in = ((cyc % 11) == 10) ? tog_pat[{a_out, b_out}] : ~tog_pat[{a_out, b_out}];
            default:  y_in = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscomp++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input vec_t v, input bit push);
        model    = v.model;
        expected = v.exp_in;
        if (push) sb.push_back(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc   = 0;
        start = 1'b0;
    endtask

    task automatic runSweep(input vec_t v, input bit abort);
        int         seq_err;
        int         done_at;
        int         done_n;
        logic [1:0] exp_ab;
        logic       exp_busy;
        vec_t       r;
        seq_err = 0;
        done_at = -1;
        done_n  = 0;
        applyStimulus(v, !abort);
        while (cyc <= 52) begin
            exp_ab   = (cyc < 44) ? 2'(cyc / 11) : 2'd0;
            exp_busy = (cyc <= 44);
            if (abort && cyc >= 23) begin
                exp_ab   = 2'd0;
                exp_busy = 1'b0;
            end
            if ({a_out, b_out} !== exp_ab || busy !== exp_busy) seq_err++;
            if (cyc == 0 && (tt !== 4'd0 || pass !== 1'b0 || mismatch_cnt !== 3'd0 || err_idx !== 2'd0)) seq_err++;
            if (!abort && cyc > 45 && (tt !== v.tt || pass !== v.pass)) seq_err++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
                if (!abort && sb.size() > 0) begin
                    r = sb.pop_front();
                    checkOutput("tt", 32'(tt), 32'(r.tt));
                    checkOutput("pass", 32'(pass), 32'(r.pass));
                    checkOutput("mismatch_cnt", 32'(mismatch_cnt), 32'(r.cnt));
                    checkOutput("err_idx", 32'(err_idx), 32'(r.err));
                end
            end
            if (abort && cyc == 23) begin
                rst_n = 1'b1;
                checkOutput("abort_outputs",
                    32'({a_out, b_out, busy, done, pass, mismatch_cnt, err_idx}), 32'd0);
                checkOutput("abort_tt", 32'(tt), 32'd0);
            end
            if (abort && cyc == 22) rst_n = 1'b0;
            if (cyc == 1) expected = ~v.exp_in;
            start = (v.restarts && (cyc == 4 || cyc == 19)) || (v.report_start && cyc == 44);
            tick();
        end
        start = 1'b0;
        rst_n = 1'b1;
        checkOutput("ab_busy_sequence", 32'(seq_err), 32'd0);
        if (abort) begin
            checkOutput("abort_no_done", 32'(done_n), 32'd0);
        end else begin
            checkOutput("done_cycle", 32'(done_at), 32'd45);
            checkOutput("done_count", 32'(done_n), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic runShortSweep();
        int seq_err;
        int done_at;
        int done_n;
        seq_err   = 0;
        done_at   = -1;
        done_n    = 0;
        expected1 = 4'b1110;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        cyc    = 0;
        start1 = 1'b0;
        while (cyc <= 15) begin
            if ({a1, b1} !== ((cyc < 8) ? 2'(cyc / 2) : 2'd0)) seq_err++;
            if (done1 === 1'b1) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = cyc;
                    checkOutput("s1_pass", 32'(pass1), 32'd1);
                    checkOutput("s1_tt", 32'(tt1), 32'hE);
                    checkOutput("s1_mismatch_cnt", 32'(cnt1), 32'd0);
                end
            end
            tick();
        end
        checkOutput("s1_ab_sequence", 32'(seq_err), 32'd0);
        checkOutput("s1_done_cycle", 32'(done_at), 32'd9);
        checkOutput("s1_done_count", 32'(done_n), 32'd1);
    endtask

    initial begin
        vec_cnt   = 0;
        miscomp   = 0;
        cyc       = 0;
        model     = M_AND;
        tog_pat   = 4'b0110;
        rst_n     = 1'b0;
        start     = 1'b0;
        start1    = 1'b0;
        expected  = 4'hF;
        expected1 = 4'hF;

        tbl[0] = '{M_AND,    4'b1000, 4'b1000, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{M_XOR,    4'b1000, 4'b0110, 1'b0, 3'd3, 2'd1, 1'b0, 1'b0};
        tbl[2] = '{M_OR,     4'b1110, 4'b1110, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0};
        tbl[3] = '{M_NAND,   4'b1000, 4'b0111, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1};
        tbl[4] = '{M_AND,    4'b0000, 4'b1000, 1'b0, 3'd1, 2'd3, 1'b0, 1'b0};
        tbl[5] = '{M_TOGGLE, 4'b0110, 4'b0110, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0};

        repeat (3) tick();
        checkOutput("reset_outputs",
            32'({a_out, b_out, busy, done, pass, mismatch_cnt, err_idx}), 32'd0);
        checkOutput("reset_tt", 32'(tt), 32'd0);
        checkOutput("reset_outputs_s1", 32'({a1, b1, busy1, done1, pass1, tt1, cnt1, err1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] sweep %0d model %0d expected %b", i, tbl[i].model, tbl[i].exp_in);
            runSweep(tbl[i], 1'b0);
        end

        $display("[TB] reset abort mid-sweep");
        runSweep(tbl[1], 1'b1);
        $display("[TB] normal sweep after abort");
        runSweep(tbl[0], 1'b0);

        $display("[TB] SETTLE=1 OR sweep");
        runShortSweep();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
        $finish;
    end

endmodule
